// File: rtl/cpu_defs.sv
// Shared fetch/decode definitions: instruction opcodes, the NOP word and fetch FSM states.
package cpu_defs;

  localparam logic [4:0]  INSTR_NO_OP = 5'd0;
  localparam logic [4:0]  INSTR_JUMP  = 5'd6;
  localparam logic [4:0]  INSTR_HALT  = 5'd7;
  localparam logic [31:0] NOP_WORD    = 32'h0;

  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_REDIRECT = 2'd2,
    ST_HALT     = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_hold_buffer.sv
// One-entry hold buffer and output mux: captures the presented word on the first stalled cycle.
// Zero-latency mux; while stalled the held word is replayed so the output stays stable.
module fetch_hold_buffer
  import cpu_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        stall,
  input  logic        clear,
  input  logic [31:0] rdata,
  output logic [31:0] instr
);

  logic [31:0] hold_reg;
  logic        hold_valid;
  logic        capture;

  // Only the first stalled cycle captures; later stall cycles keep the original word.
  assign capture = run && stall && !hold_valid;

  reg_async_reset #(.W(32), .RST_VAL(NOP_WORD)) u_hold_reg (
    .clk (clk),
    .rst (rst),
    .en  (capture),
    .d   (rdata),
    .q   (hold_reg)
  );

  reg_async_reset #(.W(1), .RST_VAL(1'b0)) u_hold_valid (
    .clk (clk),
    .rst (rst),
    .en  (capture || clear),
    .d   (!clear),
    .q   (hold_valid)
  );

  assign instr = !run      ? NOP_WORD :
                 hold_valid ? hold_reg : rdata;

endmodule

// File: rtl/reg_async_reset.sv
// Enabled register with asynchronous active-high reset to RST_VAL.
// Latency 1 cycle; holds its value while en is low.
module reg_async_reset #(
  parameter int unsigned      W       = 32,
  parameter logic [W-1:0]     RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/stage_fetch.sv
// Fetch stage: owns the PC, reads a synchronous imem, resolves decode redirects and halts.
// Address-to-output 1 cycle; stall freezes PC and replays the held word; taken jump costs squash + 1 bubble.
module stage_fetch
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter logic [31:0] PC_INCR  = 32'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [4:0]  decode_instruction_type,
  input  logic [31:0] forwarded_jump_condition,
  input  logic [31:0] forwarded_jump_address,
  output logic [31:0] imem_raddr,
  output logic        imem_ren,
  input  logic [31:0] imem_rdata,
  output logic [31:0] current_instruction,
  output logic [31:0] fetch_pc,
  output logic        squash,
  output logic        halted
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  pc_d;
  logic         pc_en;
  logic         fetch_pc_en;
  logic         run;
  logic         taken;
  logic         halt_now;
  logic         advance;
  logic         hold_clear;

  assign run   = (state == ST_RUN);
  assign taken = (decode_instruction_type == INSTR_JUMP) &&
                 (forwarded_jump_condition != 32'h0) && !stall;

  // A taken jump outranks a HALT word sitting in the output slot.
  assign halt_now    = run && !stall && !taken && (current_instruction[4:0] == INSTR_HALT);
  assign advance     = run && !stall && !taken && !halt_now;
  assign fetch_pc_en = advance || (state == ST_REDIRECT);
  assign hold_clear  = run && (taken || advance);

  always_comb begin
    pc_en = 1'b0;
    pc_d  = pc + PC_INCR;
    case (state)
      ST_BOOT, ST_REDIRECT: pc_en = 1'b1;
      ST_RUN: begin
        if (taken) begin
          pc_en = 1'b1;
          pc_d  = forwarded_jump_address;
        end else begin
          pc_en = advance;
        end
      end
      default: pc_en = 1'b0;
    endcase
  end

  reg_async_reset #(.W(32), .RST_VAL(RESET_PC)) u_pc (
    .clk (clk),
    .rst (rst),
    .en  (pc_en),
    .d   (pc_d),
    .q   (pc)
  );

  reg_async_reset #(.W(32), .RST_VAL(RESET_PC)) u_fetch_pc (
    .clk (clk),
    .rst (rst),
    .en  (fetch_pc_en),
    .d   (pc),
    .q   (fetch_pc)
  );

  fetch_hold_buffer u_hold (
    .clk   (clk),
    .rst   (rst),
    .run   (run),
    .stall (stall),
    .clear (hold_clear),
    .rdata (imem_rdata),
    .instr (current_instruction)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_BOOT;
    end else begin
      case (state)
        ST_BOOT:     state <= ST_RUN;
        ST_RUN: begin
          if (taken) begin
            state <= ST_REDIRECT;
          end else if (halt_now) begin
            state <= ST_HALT;
          end
        end
        ST_REDIRECT: state <= ST_RUN;
        default:     state <= ST_HALT;
      endcase
    end
  end

  always_comb begin
    imem_ren = 1'b1;
    case (state)
      ST_RUN:  imem_ren = !stall;
      ST_HALT: imem_ren = 1'b0;
      default: imem_ren = 1'b1;
    endcase
  end

  assign imem_raddr = pc;
  assign squash     = taken && (state != ST_HALT);
  assign halted     = (state == ST_HALT);

endmodule

// File: tb/tb_stage_fetch.sv
// Bench for stage_fetch: directed literal checks followed by randomized traffic against a
// reference model that tracks PC/fetch address and derives the presented word as mem[fetch_pc].
module tb_stage_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic [4:0]  dtype = 5'd0;
  logic [31:0] jcond = 32'h0;
  logic [31:0] jaddr = 32'h0;
  logic [31:0] imem_raddr;
  logic        imem_ren;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] cur;
  logic [31:0] fpc;
  logic        squash;
  logic        halted;

  logic [31:0] mem [256];

  int checks = 0;
  int errors = 0;

  bit          m_boot = 1'b1;
  bit          m_bubble = 1'b0;
  bit          m_halted = 1'b0;
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_fpc = 32'h0;

  always #5 clk = ~clk;

  stage_fetch dut (
    .clk                      (clk),
    .rst                      (rst),
    .stall                    (stall),
    .decode_instruction_type  (dtype),
    .forwarded_jump_condition (jcond),
    .forwarded_jump_address   (jaddr),
    .imem_raddr               (imem_raddr),
    .imem_ren                 (imem_ren),
    .imem_rdata               (imem_rdata),
    .current_instruction      (cur),
    .fetch_pc                 (fpc),
    .squash                   (squash),
    .halted                   (halted)
  );

  // Synchronous-read instruction memory: data holds when not enabled.
  always @(posedge clk) begin
    if (imem_ren) imem_rdata <= mem[imem_raddr[7:0]];
  end

  function automatic bit m_taken();
    return (dtype == 5'd6) && (jcond != 32'h0) && !stall;
  endfunction

  // Reference model advance at each rising edge.
  always @(posedge clk) begin
    if (!rst) begin
      if (m_halted) begin
      end else if (m_boot) begin
        m_pc   = m_pc + 32'd1;
        m_boot = 1'b0;
      end else if (m_bubble) begin
        m_fpc    = m_pc;
        m_pc     = m_pc + 32'd1;
        m_bubble = 1'b0;
      end else if (m_taken()) begin
        m_pc     = jaddr;
        m_bubble = 1'b1;
      end else if (!stall) begin
        if (mem[m_fpc[7:0]][4:0] == 5'd7) begin
          m_halted = 1'b1;
        end else begin
          m_fpc = m_pc;
          m_pc  = m_pc + 32'd1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and compare every output against the model.
  task automatic step(input bit r, input bit s, input logic [4:0] t,
                      input logic [31:0] c, input logic [31:0] a);
    logic [31:0] e_cur;
    logic        e_ren;
    logic        e_sq;
    logic        e_halt;
    @(negedge clk);
    rst = r; stall = s; dtype = t; jcond = c; jaddr = a;
    if (r) begin
      m_pc = 32'h0; m_fpc = 32'h0; m_boot = 1'b1; m_bubble = 1'b0; m_halted = 1'b0;
    end
    #1;
    if (m_halted) begin
      e_cur = 32'h0; e_ren = 1'b0; e_sq = 1'b0; e_halt = 1'b1;
    end else if (m_boot || m_bubble) begin
      e_cur = 32'h0; e_ren = 1'b1; e_sq = m_taken(); e_halt = 1'b0;
    end else begin
      e_cur = mem[m_fpc[7:0]]; e_ren = !s; e_sq = m_taken(); e_halt = 1'b0;
    end
    chk("current_instruction", cur, e_cur);
    chk("imem_ren", {31'h0, imem_ren}, {31'h0, e_ren});
    chk("imem_raddr", imem_raddr, m_pc);
    chk("fetch_pc", fpc, m_fpc);
    chk("squash", {31'h0, squash}, {31'h0, e_sq});
    chk("halted", {31'h0, halted}, {31'h0, e_halt});
  endtask

  task automatic go(input bit s);
    step(1'b0, s, 5'd0, 32'h0, 32'h0);
  endtask

  initial begin
    logic [31:0] w;
    bit          r;
    bit          s;
    logic [4:0]  t;
    logic [31:0] c;
    logic [31:0] a;

    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0] = 32'h21; mem[1] = 32'h41; mem[2] = 32'h61; mem[3] = 32'h81;
    mem[8'h40] = 32'hA5; mem[8'h41] = 32'hC3;

    // Reset state and sequential fetch with a three-cycle stall.
    step(1'b1, 1'b0, 5'd0, 32'h0, 32'h0);
    chk("rst_cur", cur, 32'h0);
    chk("rst_raddr", imem_raddr, 32'h0);
    chk("rst_ren", {31'h0, imem_ren}, 32'h1);
    go(1'b0); chk("c0_cur", cur, 32'h0);  chk("c0_raddr", imem_raddr, 32'h0);
    go(1'b0); chk("c1_cur", cur, 32'h21); chk("c1_fpc", fpc, 32'h0); chk("c1_raddr", imem_raddr, 32'h1);
    go(1'b1); chk("c2_cur", cur, 32'h41); chk("c2_ren", {31'h0, imem_ren}, 32'h0); chk("c2_raddr", imem_raddr, 32'h2);
    go(1'b1); chk("c3_cur", cur, 32'h41); chk("c3_raddr", imem_raddr, 32'h2);
    go(1'b1); chk("c4_cur", cur, 32'h41);
    go(1'b0); chk("c5_cur", cur, 32'h41); chk("c5_fpc", fpc, 32'h1);
    go(1'b0); chk("c6_cur", cur, 32'h61); chk("c6_fpc", fpc, 32'h2); chk("c6_raddr", imem_raddr, 32'h3);

    // Taken jump: squash, one bubble, then the target.
    step(1'b0, 1'b0, 5'd6, 32'd5, 32'h40);
    chk("jmp_cur", cur, 32'h81); chk("jmp_squash", {31'h0, squash}, 32'h1);
    go(1'b0); chk("bub_cur", cur, 32'h0); chk("bub_raddr", imem_raddr, 32'h40);
    go(1'b0); chk("tgt_cur", cur, 32'hA5); chk("tgt_fpc", fpc, 32'h40);
    // Not-taken jump keeps sequential flow.
    step(1'b0, 1'b0, 5'd6, 32'd0, 32'h10);
    chk("nt_squash", {31'h0, squash}, 32'h0); chk("nt_cur", cur, 32'hC3);
    go(1'b0); chk("nt_fpc", fpc, 32'h42);

    // HALT at address 2: presented once, then frozen until reset.
    mem[2] = 32'h07;
    step(1'b1, 1'b0, 5'd0, 32'h0, 32'h0);
    go(1'b0); go(1'b0); go(1'b0);
    go(1'b0); chk("h_cur", cur, 32'h07); chk("h_halted", {31'h0, halted}, 32'h0);
    go(1'b0); chk("h1_cur", cur, 32'h0); chk("h1_halted", {31'h0, halted}, 32'h1); chk("h1_ren", {31'h0, imem_ren}, 32'h0);
    go(1'b1); chk("h2_cur", cur, 32'h0); chk("h2_raddr", imem_raddr, 32'h3);
    step(1'b1, 1'b0, 5'd0, 32'h0, 32'h0);
    chk("hr_halted", {31'h0, halted}, 32'h0); chk("hr_raddr", imem_raddr, 32'h0);

    // Jump in the HALT cycle wins; reset lands in the middle of the redirect.
    go(1'b0); go(1'b0); go(1'b0);
    step(1'b0, 1'b0, 5'd6, 32'd1, 32'h40);
    chk("jh_cur", cur, 32'h07); chk("jh_squash", {31'h0, squash}, 32'h1);
    go(1'b0); chk("jh_halted", {31'h0, halted}, 32'h0); chk("jh_raddr", imem_raddr, 32'h40);
    step(1'b1, 1'b0, 5'd0, 32'h0, 32'h0);
    chk("jr_cur", cur, 32'h0); chk("jr_raddr", imem_raddr, 32'h0);
    go(1'b0); go(1'b0); chk("jr_restart", cur, 32'h21);

    // Randomized episodes, including targets near the top of the address space.
    for (int ep = 0; ep < 6; ep++) begin
      for (int i = 0; i < 256; i++) begin
        w = $urandom;
        if (w[4:0] == 5'd7 && $urandom_range(0, 3) != 0) w[0] = 1'b0;
        mem[i] = w;
      end
      step(1'b1, 1'b0, 5'd0, 32'h0, 32'h0);
      for (int n = 0; n < 600; n++) begin
        r = ($urandom_range(0, 199) == 0) || (m_halted && $urandom_range(0, 15) == 0);
        s = ($urandom_range(0, 3) == 0);
        t = ($urandom_range(0, 5) == 0) ? 5'd6 : 5'($urandom_range(0, 31));
        c = ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom;
        a = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 255))
                                        : (32'hFFFFFF00 | 32'($urandom_range(0, 255)));
        if (r) t = 5'd0;
        step(r, s, t, c, a);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
